alu_mp_seq: RTL and testbench
=============================

// Module: alu_mp_seq
// PURPOSE
//  Multi-precision sequencer that sits directly upstream of the 16-bit 181/182 ALU (alu_181).
//  Accepts one NWORDS*WORD-bit operation per valid/ready request and walks the ALU LSB word first, one word per cycle.
//  Chains the active-low carry from each word's carry_out into the next word's carry_in.
//  Assembles the full-width result, the final carry and the word-wise ANDed equal flag into one response.
// PARAMETERS
//  WORD    16  ALU slice width; must match the attached ALU WIDTH
//  NWORDS  4   words per operation; result width = WORD*NWORDS; NWORDS >= 1
// PORTS
//  clk            in   1             rising-edge clock
//  rst_n          in   1             async active-low reset
//  req_valid      in   1             request present
//  req_ready      out  1             block can accept a request
//  req_a          in   WORD*NWORDS   operand A
//  req_b          in   WORD*NWORDS   operand B
//  req_op         in   4             181 S select
//  req_mode       in   1             181 M (1 = logic, 0 = arithmetic)
//  req_carry_n    in   1             active-low carry into word 0
//  resp_valid     out  1             response present
//  resp_ready     in   1             consumer takes response
//  resp_result    out  WORD*NWORDS   assembled F
//  resp_carry_n   out  1             active-low carry out of the top word
//  resp_equal     out  1             AND of every word's equal_out
//  alu_a          out  WORD          to ALU A_in
//  alu_b          out  WORD          to ALU B_in
//  alu_op         out  4             to ALU op_in
//  alu_mode       out  1             to ALU mode
//  alu_carry_n    out  1             to ALU carry_in
//  alu_out        in   WORD          from ALU out
//  alu_carry_out  in   1             from ALU carry_out (active-low)
//  alu_equal      in   1             from ALU equal_out
// BEHAVIOUR
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//  - Reset (async, any state, including mid-RUN):
//      state IDLE, idx 0; req_ready 1; resp_valid 0; resp_result 0; resp_carry_n 1; resp_equal 0.
//      Captured operands, op, mode and carry are cleared. Any in-flight operation is dropped and produces no response.
//  - IDLE: req_ready=1. On req_valid:
//      capture a, b, op, mode and carry_n; set idx=0, eq_acc=1, carry reg=req_carry_n; go to RUN.
//  - RUN: req_ready=0. The ALU is combinational; its outputs are sampled at the end of the same cycle.
//      Drive alu_a=a[idx*WORD+:WORD], alu_b=b[idx*WORD+:WORD], alu_op=op, alu_mode=mode, alu_carry_n=carry reg.
//      At each edge: result[idx]<=alu_out; carry reg<=alu_carry_out; eq_acc<=eq_acc&alu_equal; idx++.
//      Leave RUN for DONE at the edge where idx==NWORDS-1.
//  - Carry is chained in both modes. In logic mode it does not affect F but is still reported.
//  - DONE: resp_valid=1. resp_result, resp_carry_n (= last carry reg) and resp_equal (= eq_acc) are registered.
//      These outputs hold stable until the handshake. On resp_ready, go to IDLE. req_valid is ignored in DONE.
//  - Outside RUN: alu_a=alu_b=0, alu_carry_n=1, alu_op/alu_mode hold the captured values.
//  - Latency: resp_valid rises exactly NWORDS cycles after the accept edge.
//      Minimum issue interval is NWORDS+2 cycles (DONE and IDLE each take at least one cycle).
//  - resp_result/carry/equal keep their last values after the handshake until the next operation overwrites them.
//  - NWORDS=1: RUN lasts one cycle; same rules apply.
//  - idx is a $clog2(NWORDS)-bit counter (minimum 1 bit). It never wraps, because RUN exits at NWORDS-1.
// TESTING (WORD=16, NWORDS=4, real alu_181 attached; carries active-low)
//  1. A=0x00000000FFFFFFFF, B=1, op=1001, mode=0, carry_n=1
//       -> result 0x0000000100000000, carry_n=1; resp_valid exactly 4 cycles after accept.
//  2. A=0xFFFFFFFFFFFFFFFF, B=1, op=1001, mode=0, carry_n=1
//       -> result 0, resp_carry_n=0 (carry ripples through all 4 words).
//  3. A=B=0x123456789ABCDEF0, op=0110, mode=0, carry_n=1
//       -> result 0xFFFFFFFFFFFFFFFF, resp_equal=1.
//     Repeat with B bit 40 flipped -> resp_equal=0.
//  4. op=0110, mode=1, A=0xF0F0F0F0F0F0F0F0, B=0xFFFF00000000FFFF
//       -> result 0x0F0FF0F0F0F00F0F (XOR).
//  5. Hold resp_ready=0 for 5 cycles in DONE with req_valid=1
//       -> outputs stable, req_ready=0, no second accept.
//     Release -> the next request is accepted one cycle after the handshake.
//  6. Pulse rst_n low while in RUN at idx=2
//       -> immediately IDLE, resp_valid=0, req_ready=1; a following test-1 request completes correctly.

Source files
------------

// File: rtl/alu_mp_seq.sv
// rtl/alu_mp_seq.sv - multi-precision sequencer for the 16-bit 181/182 ALU
// Walks one wide operation through the ALU one word per cycle, LSB word first.
module alu_mp_seq #(
   parameter int WORD   = 16,
   parameter int NWORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WORD*NWORDS-1:0] req_a,
   input  logic [WORD*NWORDS-1:0] req_b,
   input  logic [3:0]             req_op,
   input  logic                   req_mode,
   input  logic                   req_carry_n,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [WORD*NWORDS-1:0] resp_result,
   output logic                   resp_carry_n,
   output logic                   resp_equal,
   output logic [WORD-1:0]        alu_a,
   output logic [WORD-1:0]        alu_b,
   output logic [3:0]             alu_op,
   output logic                   alu_mode,
   output logic                   alu_carry_n,
   input  logic [WORD-1:0]        alu_out,
   input  logic                   alu_carry_out,
   input  logic                   alu_equal
);

   localparam int W  = WORD * NWORDS;
   localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    acc;
   logic [W-1:0]    acc_nxt;
   logic [3:0]      op_reg;
   logic            mode_reg;
   logic            carry_reg;
   logic            eq_acc;
   logic [IW-1:0]   idx;
   logic            last;

   assign last = (idx == IW'(NWORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid)  state_nxt = RUN;
         RUN:     if (last)       state_nxt = DONE;
         DONE:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (state == IDLE);
      resp_valid  = (state == DONE);
      alu_op      = op_reg;
      alu_mode    = mode_reg;
      alu_a       = '0;
      alu_b       = '0;
      alu_carry_n = 1'b1;
      if (state == RUN) begin
         alu_a       = a_reg[idx*WORD +: WORD];
         alu_b       = b_reg[idx*WORD +: WORD];
         alu_carry_n = carry_reg;
      end
   end

   // Merge the current ALU word so the final edge can publish the full result at once.
   always_comb begin
      acc_nxt = acc;
      acc_nxt[idx*WORD +: WORD] = alu_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg        <= '0;
         b_reg        <= '0;
         acc          <= '0;
         op_reg       <= '0;
         mode_reg     <= 1'b0;
         carry_reg    <= 1'b1;
         eq_acc       <= 1'b0;
         idx          <= '0;
         resp_result  <= '0;
         resp_carry_n <= 1'b1;
         resp_equal   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_reg     <= req_a;
                  b_reg     <= req_b;
                  op_reg    <= req_op;
                  mode_reg  <= req_mode;
                  carry_reg <= req_carry_n;
                  eq_acc    <= 1'b1;
                  idx       <= '0;
               end
            end
            RUN: begin
               acc       <= acc_nxt;
               carry_reg <= alu_carry_out;
               eq_acc    <= eq_acc & alu_equal;
               if (last) begin
                  idx          <= '0;
                  resp_result  <= acc_nxt;
                  resp_carry_n <= alu_carry_out;
                  resp_equal   <= eq_acc & alu_equal;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mp_seq.sv
// tb/tb_alu_mp_seq.sv - self-checking bench for alu_mp_seq with a behavioural 181 ALU attached
module tb_alu_mp_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_op;
   logic        req_mode;
   logic        req_carry_n;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_result;
   logic        resp_carry_n;
   logic        resp_equal;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_op;
   logic        alu_mode;
   logic        alu_carry_n;
   logic [15:0] alu_out;
   logic        alu_carry_out;
   logic        alu_equal;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_res;
   logic        exp_cn;
   logic        exp_eq;

   alu_mp_seq #(.WORD(16), .NWORDS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mode(req_mode),
      .req_carry_n(req_carry_n),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_carry_n(resp_carry_n), .resp_equal(resp_equal),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
      .alu_carry_n(alu_carry_n),
      .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_equal(alu_equal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 16-bit 181 with active-high data: F = X + Y + Cin (arith) or ~(X ^ Y) (logic).
   function automatic logic [17:0] alu181(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] s, input logic m, input logic cn);
      logic [15:0] x, y, f;
      logic [16:0] sum;
      x   = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
      y   = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
      sum = {1'b0, x} + {1'b0, y} + {16'd0, ~cn};
      f   = m ? ~(x ^ y) : sum[15:0];
      return {~sum[16], &f, f};
   endfunction

   always_comb {alu_carry_out, alu_equal, alu_out} = alu181(alu_a, alu_b, alu_op, alu_mode, alu_carry_n);

   // Whole-width reference: one 64-bit operation, no word chaining.
   function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] s, input logic m, input logic cn);
      logic [63:0] x, y, f;
      logic [64:0] sum;
      x   = a | (b & {64{s[0]}}) | (~b & {64{s[1]}});
      y   = (a & ~b & {64{s[2]}}) | (a & b & {64{s[3]}});
      sum = {1'b0, x} + {1'b0, y} + {64'd0, ~cn};
      f   = m ? ~(x ^ y) : sum[63:0];
      return {~sum[64], &f, f};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                       input logic m, input logic cn);
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20) check("req_ready_timeout", {63'd0, req_ready}, 64'd1);
      req_a = a; req_b = b; req_op = op; req_mode = m; req_carry_n = cn;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd4);
      check({tag, "_result"}, resp_result, exp_res);
      check({tag, "_carry_n"}, {63'd0, resp_carry_n}, {63'd0, exp_cn});
      check({tag, "_equal"}, {63'd0, resp_equal}, {63'd0, exp_eq});
   endtask

   task automatic handshake(input string tag);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, "_valid_drop"}, {63'd0, resp_valid}, 64'd0);
      check({tag, "_result_hold"}, resp_result, exp_res);
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic m, input logic cn,
                         input logic [63:0] eres, input logic ecn, input logic eeq);
      exp_res = eres; exp_cn = ecn; exp_eq = eeq;
      send(a, b, op, m, cn);
      wait_resp(tag);
      handshake(tag);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [3:0]  rop;
      logic        rm, rcn;
      logic [65:0] r;

      rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      req_a = '0; req_b = '0; req_op = '0; req_mode = 1'b0; req_carry_n = 1'b1;
      #12;
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_result", resp_result, 64'd0);
      check("rst_carry_n", {63'd0, resp_carry_n}, 64'd1);
      check("rst_equal", {63'd0, resp_equal}, 64'd0);
      check("rst_alu_carry_n", {63'd0, alu_carry_n}, 64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("t1_add", 64'h0000_0000_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b1,
             64'h0000_0001_0000_0000, 1'b1, 1'b0);
      run_op("t2_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b1,
             64'd0, 1'b0, 1'b0);
      run_op("t3_eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'b0110, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      run_op("t3_neq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5778_9ABC_DEF0, 4'b0110, 1'b0, 1'b1,
             64'hFFFF_FEFF_FFFF_FFFF, 1'b1, 1'b0);
      run_op("t4_xor", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_0000_0000_FFFF, 4'b0110, 1'b1, 1'b1,
             64'h0F0F_F0F0_F0F0_0F0F, 1'b1, 1'b0);

      // Back-pressure in DONE with a competing request waiting.
      exp_res = 64'h0000_0001_0000_0000; exp_cn = 1'b1; exp_eq = 1'b0;
      send(64'h0000_0000_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b1);
      wait_resp("t5_first");
      req_a = 64'd5; req_b = 64'd7; req_op = 4'b1001; req_mode = 1'b0; req_carry_n = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t5_hold_valid", {63'd0, resp_valid}, 64'd1);
         check("t5_hold_ready", {63'd0, req_ready}, 64'd0);
         check("t5_hold_result", resp_result, exp_res);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("t5_idle_after_hs", {63'd0, req_ready}, 64'd1);
      @(posedge clk); #1;
      check("t5_accept_next", {63'd0, req_ready}, 64'd0);
      req_valid = 1'b0;
      exp_res = 64'd13; exp_cn = 1'b1; exp_eq = 1'b0;
      wait_resp("t5_second");
      handshake("t5_second");

      // Reset mid-RUN at idx 2 drops the operation.
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t6_idx2_alu_a", {48'd0, alu_a}, 64'h0000_0000_0000_FFFF);
      check("t6_idx2_carry", {63'd0, alu_carry_n}, 64'd0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {63'd0, resp_valid}, 64'd0);
      check("t6_rst_ready", {63'd0, req_ready}, 64'd1);
      check("t6_rst_result", resp_result, 64'd0);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("t6_no_resp", {63'd0, resp_valid}, 64'd0);
      run_op("t6_after", 64'h0000_0000_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b1,
             64'h0000_0001_0000_0000, 1'b1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         rop = 4'($urandom_range(0, 15));
         rm  = 1'($urandom_range(0, 1));
         rcn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            rb = ra; rop = 4'b0110; rm = 1'b0;
         end
         r = ref_op(ra, rb, rop, rm, rcn);
         exp_res = r[63:0]; exp_eq = r[64]; exp_cn = r[65];
         send(ra, rb, rop, rm, rcn);
         wait_resp("rnd");
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check("rnd_stable", resp_result, exp_res);
         end
         handshake("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
